// File: rtl/switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : switch_sequencer
// Purpose  : Walks a four-switch combination lock from its current state to a
//            requested target state, one switch press at a time, while keeping
//            a registered mirror of the lock state.
//            Each press drives one output high for HOLD cycles and is followed
//            by GAP all-low cycles. The mirror advances to the hop destination
//            when the GAP begins.
// Ports    : clk          rising-edge clock for all state
//            reset        synchronous active-high reset
//            req_valid    a target-state request is present
//            req_target   requested lock state code (0-4 legal)
//            req_ready    high in IDLE; accept on req_valid & req_ready
//            SW1..SW4     switch drives to the lock
//            lock_rst     lock reset press
//            mirror_state registered model of the lock state
//            mirror_z     Z encoding of mirror_state
//            busy         high while a press or gap is in progress
//            done         one-cycle pulse when a request completes
//            err          one-cycle pulse when a request is rejected
// Revision : 1.0  initial release
// ============================================================================
module switch_sequencer #(
   parameter int HOLD = 2,
   parameter int GAP  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [2:0] req_target,
   output logic       req_ready,
   output logic       SW1,
   output logic       SW2,
   output logic       SW3,
   output logic       SW4,
   output logic       lock_rst,
   output logic [2:0] mirror_state,
   output logic [1:0] mirror_z,
   output logic       busy,
   output logic       done,
   output logic       err
);

   // Counters count down to zero, so they load one less than the duration.
   localparam logic [3:0] c_HOLD_LOAD = 4'(HOLD - 1);
   localparam logic [3:0] c_GAP_LOAD  = 4'(GAP - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Which output a press drives. SW4 has no transition in the lock model,
   // so the hop planner never selects it; the port stays low.
   typedef enum logic [2:0] {
      HOP_NONE = 3'd0,
      HOP_SW1  = 3'd1,
      HOP_SW2  = 3'd2,
      HOP_SW3  = 3'd3,
      HOP_SW4  = 3'd4,
      HOP_RST  = 3'd5
   } hop_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic [2:0] r_mirror;
   logic [2:0] w_mirror_nxt;
   logic [2:0] r_target;
   logic [2:0] w_target_nxt;
   hop_t       r_hop;
   hop_t       w_hop_nxt;
   logic       r_rej;       // the DONE cycle reports a rejection, not a completion
   logic       w_rej_nxt;

   // Next press needed to move from cur toward tgt (tgt assumed 0-4, != cur).
   function automatic hop_t f_next_hop(input logic [2:0] cur, input logic [2:0] tgt);
      hop_t h;
      h = HOP_NONE;
      if (tgt == 3'd0) begin
         h = (cur != 3'd0) ? HOP_RST : HOP_NONE;
      end else begin
         case (cur)
            3'd0: h = (tgt <= 3'd2) ? HOP_SW1 : HOP_SW3;
            3'd1: h = HOP_SW2;
            3'd2: h = (tgt == 3'd1) ? HOP_SW2 : HOP_SW3;
            3'd3: h = (tgt == 3'd4) ? HOP_SW1 : HOP_SW2;
            3'd4: h = HOP_SW2;
            default: h = HOP_NONE;
         endcase
      end
      return h;
   endfunction

   // Lock state reached from cur after the given press.
   function automatic logic [2:0] f_apply_hop(input logic [2:0] cur, input hop_t hop);
      logic [2:0] nxt;
      nxt = cur;
      case (hop)
         HOP_RST: nxt = 3'd0;
         HOP_SW1: begin
            if (cur == 3'd0)      nxt = 3'd1;
            else if (cur == 3'd3) nxt = 3'd4;
         end
         HOP_SW2: begin
            if (cur == 3'd1)                                      nxt = 3'd2;
            else if (cur == 3'd2 || cur == 3'd3 || cur == 3'd4) nxt = 3'd1;
         end
         HOP_SW3: begin
            if (cur == 3'd0 || cur == 3'd2) nxt = 3'd3;
         end
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 4'd0;
         r_mirror <= 3'd0;
         r_target <= 3'd0;
         r_hop    <= HOP_NONE;
         r_rej    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_mirror <= w_mirror_nxt;
         r_target <= w_target_nxt;
         r_hop    <= w_hop_nxt;
         r_rej    <= w_rej_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_mirror_nxt = r_mirror;
      w_target_nxt = r_target;
      w_hop_nxt    = r_hop;
      w_rej_nxt    = r_rej;

      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_rej_nxt = 1'b0;
               if (req_target > 3'd4) begin
                  // Rejected: reported through the DONE slot, no press.
                  w_rej_nxt   = 1'b1;
                  w_state_nxt = ST_DONE;
               end else if (req_target == r_mirror) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_target_nxt = req_target;
                  w_hop_nxt    = f_next_hop(r_mirror, req_target);
                  w_cnt_nxt    = c_HOLD_LOAD;
                  w_state_nxt  = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (r_cnt == 4'd0) begin
               // Press released: the lock is now in the hop destination.
               w_mirror_nxt = f_apply_hop(r_mirror, r_hop);
               w_cnt_nxt    = c_GAP_LOAD;
               w_state_nxt  = ST_GAP;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_GAP: begin
            if (r_cnt == 4'd0) begin
               if (r_mirror == r_target) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_hop_nxt   = f_next_hop(r_mirror, r_target);
                  w_cnt_nxt   = c_HOLD_LOAD;
                  w_state_nxt = ST_HOLD;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode: drives only while in HOLD, so at most one is ever high.
   always_comb begin
      req_ready    = (r_state == ST_IDLE);
      busy         = (r_state == ST_HOLD) || (r_state == ST_GAP);
      done         = (r_state == ST_DONE) && !r_rej;
      err          = (r_state == ST_DONE) && r_rej;
      SW1          = (r_state == ST_HOLD) && (r_hop == HOP_SW1);
      SW2          = (r_state == ST_HOLD) && (r_hop == HOP_SW2);
      SW3          = (r_state == ST_HOLD) && (r_hop == HOP_SW3);
      SW4          = (r_state == ST_HOLD) && (r_hop == HOP_SW4);
      lock_rst     = (r_state == ST_HOLD) && (r_hop == HOP_RST);
      mirror_state = r_mirror;
      mirror_z     = 2'b01;
      case (r_mirror)
         3'd2, 3'd4: mirror_z = 2'b10;
         3'd3:       mirror_z = 2'b11;
         default:    mirror_z = 2'b01;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_switch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_sequencer
// Purpose  : Self-checking bench for switch_sequencer (HOLD=2, GAP=2).
//            A table of requests with hand-derived press paths is expanded
//            into per-cycle expected output records on acceptance; a monitor
//            pops and compares one record per cycle. Reset corners are
//            checked by hand-written sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_switch_sequencer;

   localparam int c_HOLD = 2;
   localparam int c_GAP  = 2;

   logic       clk;
   logic       reset;
   logic       req_valid;
   logic [2:0] req_target;
   logic       req_ready;
   logic       SW1, SW2, SW3, SW4, lock_rst;
   logic [2:0] mirror_state;
   logic [1:0] mirror_z;
   logic       busy, done, err;

   switch_sequencer #(.HOLD(c_HOLD), .GAP(c_GAP)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_target   (req_target),
      .req_ready    (req_ready),
      .SW1          (SW1),
      .SW2          (SW2),
      .SW3          (SW3),
      .SW4          (SW4),
      .lock_rst     (lock_rst),
      .mirror_state (mirror_state),
      .mirror_z     (mirror_z),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One request: target, number of presses, press codes and destinations
   // (3 bits each, hop 0 in the low bits). Codes: 1-4 = SW1-SW4, 5 = lock_rst.
   typedef struct packed {
      logic [2:0] tgt;
      logic [1:0] nh;
      logic [8:0] drv;
      logic [8:0] dst;
      logic       is_err;
   } vec_t;

   // Expected outputs for one cycle; drv is {SW1,SW2,SW3,SW4,lock_rst}.
   typedef struct packed {
      logic [4:0] drv;
      logic       busy;
      logic       done;
      logic       err;
      logic       ready;
      logic [2:0] mirror;
      logic [1:0] z;
   } exp_t;

   exp_t       sb[$];
   int         total;
   int         bad;
   logic [2:0] cur;      // bench's own idea of the lock state
   vec_t       vecs[19];

   function automatic logic [1:0] zof(input logic [2:0] s);
      case (s)
         3'd2, 3'd4: return 2'b10;
         3'd3:       return 2'b11;
         default:    return 2'b01;
      endcase
   endfunction

   function automatic logic [4:0] onehot(input logic [2:0] code);
      case (code)
         3'd1:    return 5'b10000;
         3'd2:    return 5'b01000;
         3'd3:    return 5'b00100;
         3'd4:    return 5'b00010;
         3'd5:    return 5'b00001;
         default: return 5'b00000;
      endcase
   endfunction

   task automatic push_exp(input logic [4:0] d, input logic b, input logic dn,
                           input logic e, input logic r, input logic [2:0] m);
      exp_t x;
      x.drv    = d;
      x.busy   = b;
      x.done   = dn;
      x.err    = e;
      x.ready  = r;
      x.mirror = m;
      x.z      = zof(m);
      sb.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Per-cycle scoreboard compare plus the at-most-one-drive check.
   task automatic monitor_loop();
      exp_t e;
      exp_t a;
      forever begin
         @(negedge clk);
         if (!reset) begin
            total++;
            if ($countones({SW1, SW2, SW3, SW4, lock_rst}) > 1) begin
               bad++;
               $display("FAIL onehot: drives=%b at %0t", {SW1, SW2, SW3, SW4, lock_rst}, $time);
            end
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            a.drv    = {SW1, SW2, SW3, SW4, lock_rst};
            a.busy   = busy;
            a.done   = done;
            a.err    = err;
            a.ready  = req_ready;
            a.mirror = mirror_state;
            a.z      = mirror_z;
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL cycle: got drv=%b busy=%b done=%b err=%b rdy=%b st=%0d z=%b expected drv=%b busy=%b done=%b err=%b rdy=%b st=%0d z=%b at %0t",
                        a.drv, a.busy, a.done, a.err, a.ready, a.mirror, a.z,
                        e.drv, e.busy, e.done, e.err, e.ready, e.mirror, e.z, $time);
            end
         end
      end
   endtask

   // Issue one request, keep req_valid high for the whole sequence (and
   // scramble req_target after acceptance) to prove neither is re-sampled.
   task automatic do_req(input vec_t v);
      logic [2:0] m;
      int         n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         bad++;
         total++;
         $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
      end
      req_valid  = 1'b1;
      req_target = v.tgt;
      @(posedge clk);
      m = cur;
      if (v.is_err) begin
         push_exp(5'b0, 1'b0, 1'b0, 1'b1, 1'b0, m);
      end else begin
         for (int i = 0; i < int'(v.nh); i++) begin
            for (int h = 0; h < c_HOLD; h++)
               push_exp(onehot(v.drv[3*i +: 3]), 1'b1, 1'b0, 1'b0, 1'b0, m);
            m = v.dst[3*i +: 3];
            for (int g = 0; g < c_GAP; g++)
               push_exp(5'b0, 1'b1, 1'b0, 1'b0, 1'b0, m);
         end
         push_exp(5'b0, 1'b0, 1'b1, 1'b0, 1'b0, m);
      end
      push_exp(5'b0, 1'b0, 1'b0, 1'b0, 1'b1, m);
      cur = m;
      #1 req_target = 3'($urandom_range(0, 7));
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         bad++;
         total++;
         $display("FAIL seq_timeout: %0d records left, required 0", sb.size());
         sb.delete();
      end
      req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total      = 0;
      bad        = 0;
      cur        = 3'd0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_target = 3'd0;

      //            tgt    nh     drv (h2,h1,h0)        dst (h2,h1,h0)        err
      vecs[0]  = '{3'd1, 2'd1, {3'd0, 3'd0, 3'd1}, {3'd0, 3'd0, 3'd1}, 1'b0}; // S0->1
      vecs[1]  = '{3'd4, 2'd3, {3'd1, 3'd3, 3'd2}, {3'd4, 3'd3, 3'd2}, 1'b0}; // S1->4
      vecs[2]  = '{3'd6, 2'd0, 9'd0,               9'd0,               1'b1}; // bad code
      vecs[3]  = '{3'd4, 2'd0, 9'd0,               9'd0,               1'b0}; // same state
      vecs[4]  = '{3'd3, 2'd3, {3'd3, 3'd2, 3'd2}, {3'd3, 3'd2, 3'd1}, 1'b0}; // S4->3 max
      vecs[5]  = '{3'd0, 2'd1, {3'd0, 3'd0, 3'd5}, {3'd0, 3'd0, 3'd0}, 1'b0}; // S3->0
      vecs[6]  = '{3'd0, 2'd0, 9'd0,               9'd0,               1'b0}; // same S0
      vecs[7]  = '{3'd7, 2'd0, 9'd0,               9'd0,               1'b1}; // bad code
      vecs[8]  = '{3'd2, 2'd2, {3'd0, 3'd2, 3'd1}, {3'd0, 3'd2, 3'd1}, 1'b0}; // S0->2
      vecs[9]  = '{3'd1, 2'd1, {3'd0, 3'd0, 3'd2}, {3'd0, 3'd0, 3'd1}, 1'b0}; // S2->1
      vecs[10] = '{3'd3, 2'd2, {3'd0, 3'd3, 3'd2}, {3'd0, 3'd3, 3'd2}, 1'b0}; // S1->3
      vecs[11] = '{3'd2, 2'd2, {3'd0, 3'd2, 3'd2}, {3'd0, 3'd2, 3'd1}, 1'b0}; // S3->2
      vecs[12] = '{3'd4, 2'd2, {3'd0, 3'd1, 3'd3}, {3'd0, 3'd4, 3'd3}, 1'b0}; // S2->4
      vecs[13] = '{3'd1, 2'd1, {3'd0, 3'd0, 3'd2}, {3'd0, 3'd0, 3'd1}, 1'b0}; // S4->1
      vecs[14] = '{3'd0, 2'd1, {3'd0, 3'd0, 3'd5}, {3'd0, 3'd0, 3'd0}, 1'b0}; // S1->0
      vecs[15] = '{3'd4, 2'd2, {3'd0, 3'd1, 3'd3}, {3'd0, 3'd4, 3'd3}, 1'b0}; // S0->4
      vecs[16] = '{3'd2, 2'd2, {3'd0, 3'd2, 3'd2}, {3'd0, 3'd2, 3'd1}, 1'b0}; // S4->2
      vecs[17] = '{3'd0, 2'd1, {3'd0, 3'd0, 3'd5}, {3'd0, 3'd0, 3'd0}, 1'b0}; // S2->0
      vecs[18] = '{3'd3, 2'd1, {3'd0, 3'd0, 3'd3}, {3'd0, 3'd0, 3'd3}, 1'b0}; // S0->3 after reset

      fork
         monitor_loop();
      join_none

      // Reset state.
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_mirror", 32'(mirror_state), 32'd0);
      chk("rst_z", 32'(mirror_z), 32'h1);
      chk("rst_drives", 32'({SW1, SW2, SW3, SW4, lock_rst}), 32'd0);
      chk("rst_flags", 32'({busy, done, err}), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 18; i++) do_req(vecs[i]);

      // Reset in the second cycle of a SW3 press from S0.
      @(negedge clk);
      req_valid  = 1'b1;
      req_target = 3'd3;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_t1_sw3", 32'(SW3), 32'd1);
      @(negedge clk);
      chk("abort_t2_sw3", 32'(SW3), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_t3_drives", 32'({SW1, SW2, SW3, SW4, lock_rst}), 32'd0);
      chk("abort_t3_mirror", 32'(mirror_state), 32'd0);
      chk("abort_t3_flags", 32'({busy, done, err}), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_t4_done", 32'({done, err}), 32'd0);
      chk("abort_t4_ready", 32'(req_ready), 32'd1);
      cur = 3'd0;

      do_req(vecs[18]);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
